// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access size, FSM state encoding,
// and the byte-mask lookup.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    typedef logic [2:0] lsu_state_t;

    localparam lsu_state_t StIdle  = 3'd0;
    localparam lsu_state_t StReq0  = 3'd1;
    localparam lsu_state_t StWait0 = 3'd2;
    localparam lsu_state_t StReq1  = 3'd3;
    localparam lsu_state_t StWait1 = 3'd4;
    localparam lsu_state_t StDone  = 3'd5;

    function automatic logic [3:0] size_mask(lsu_size_e size);
        case (size)
            SZ_B:    size_mask = 4'h1;
            SZ_H:    size_mask = 4'h3;
            default: size_mask = 4'hF;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-addressed data bus with req/gnt/rvalid handshake between the LSU and memory.
interface load_store_unit_if;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );

endinterface

// File: rtl/load_align.sv
// Extracts a load result from one or two fetched words: shift down by the byte offset,
// truncate to the access size, then sign- or zero-extend.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word0_i,
    input  logic [31:0] word1_i,
    input  logic [1:0]  off_i,
    input  lsu_size_e   size_i,
    input  logic        unsigned_i,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted = 32'({word1_i, word0_i} >> {off_i, 3'b000});
        case (size_i)
            SZ_B:    rdata_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
            SZ_H:    rdata_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
            default: rdata_o = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns a decoded memory op into one or two bus transactions, stalling
// the core until the access completes.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter bit MISALIGN_SPLIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        one_byte,
    input  logic        two_byte,
    input  logic        four_bytes,
    input  logic        unsigned_load,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        load_valid,
    output logic [31:0] rdata_out,
    output logic        misalign_fault,
    load_store_unit_if.master bus
);

    lsu_state_t  state_q, state_d;
    logic        is_store_q, is_store_d;
    lsu_size_e   size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [1:0]  off_q, off_d;
    logic [29:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  m8_q, m8_d;
    logic        fault_q, fault_d;
    logic [31:0] word0_q, word0_d;
    logic [31:0] word1_q, word1_d;

    lsu_size_e   size_in;
    logic [7:0]  m8_in;
    logic        cross_in;
    logic        cross_q;
    logic        req0, req1;
    logic [63:0] st_wide;
    logic [31:0] load_data;

    always_comb begin
        if (one_byte) begin
            size_in = SZ_B;
        end else if (two_byte) begin
            size_in = SZ_H;
        end else if (four_bytes) begin
            size_in = SZ_W;
        end else begin
            size_in = SZ_W;
        end
        m8_in    = {4'b0000, size_mask(size_in)} << addr[1:0];
        cross_in = |m8_in[7:4];
    end

    assign cross_q = |m8_q[7:4];

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        off_d      = off_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        m8_d       = m8_q;
        fault_d    = fault_q;
        word0_d    = word0_q;
        word1_d    = word1_q;

        case (state_q)
            StIdle: begin
                fault_d = 1'b0;
                if (mem_read | mem_write) begin
                    // A read/write conflict resolves to a write.
                    is_store_d = mem_write;
                    size_d     = size_in;
                    unsigned_d = unsigned_load;
                    off_d      = addr[1:0];
                    waddr_d    = addr[31:2];
                    wdata_d    = wdata;
                    m8_d       = m8_in;
                    if (cross_in && !MISALIGN_SPLIT) begin
                        fault_d = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StReq0;
                    end
                end
            end
            StReq0: begin
                if (bus.bus_gnt) begin
                    if (!is_store_q)  state_d = StWait0;
                    else if (cross_q) state_d = StReq1;
                    else              state_d = StDone;
                end
            end
            StWait0: begin
                if (bus.bus_rvalid) begin
                    word0_d = bus.bus_rdata;
                    state_d = cross_q ? StReq1 : StDone;
                end
            end
            StReq1: begin
                if (bus.bus_gnt) state_d = is_store_q ? StDone : StWait1;
            end
            StWait1: begin
                if (bus.bus_rvalid) begin
                    word1_d = bus.bus_rdata;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            is_store_q <= 1'b0;
            size_q     <= SZ_W;
            unsigned_q <= 1'b0;
            off_q      <= 2'b00;
            waddr_q    <= '0;
            wdata_q    <= '0;
            m8_q       <= '0;
            fault_q    <= 1'b0;
            word0_q    <= '0;
            word1_q    <= '0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            off_q      <= off_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            m8_q       <= m8_d;
            fault_q    <= fault_d;
            word0_q    <= word0_d;
            word1_q    <= word1_d;
        end
    end

    load_align u_load_align (
        .word0_i    (word0_q),
        .word1_i    (word1_q),
        .off_i      (off_q),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .rdata_o    (load_data)
    );

    // Low half of the shifted store data goes out first, high half on the second beat.
    assign st_wide = {32'b0, wdata_q} << {off_q, 3'b000};
    assign req0    = (state_q == StReq0);
    assign req1    = (state_q == StReq1);

    always_comb begin
        stall = ~rst & (((state_q == StIdle) & (mem_read | mem_write)) |
                        ((state_q != StIdle) & (state_q != StDone)));
        load_valid     = (state_q == StDone) & ~is_store_q & ~fault_q;
        rdata_out      = load_valid ? load_data : 32'b0;
        misalign_fault = (state_q == StDone) & fault_q;

        bus.bus_req   = req0 | req1;
        bus.bus_we    = (req0 | req1) & is_store_q;
        bus.bus_addr  = 32'b0;
        bus.bus_be    = 4'b0;
        bus.bus_wdata = 32'b0;
        if (req0) begin
            bus.bus_addr  = {waddr_q, 2'b00};
            bus.bus_be    = m8_q[3:0];
            bus.bus_wdata = st_wide[31:0];
        end else if (req1) begin
            bus.bus_addr  = {waddr_q + 30'd1, 2'b00};
            bus.bus_be    = m8_q[7:4];
            bus.bus_wdata = st_wide[63:32];
        end
    end

endmodule
